// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared states, defaults and FIFO entry layout for the RSA sequencer
package rsa_pkg;

    localparam int RSA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYGEN = 3'd1,
        ST_READY  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_EXP    = 3'd4,
        ST_OUT    = 3'd5
    } rsa_state_e;

    // FIFO entry: WIDTH+1 bits, encrypt flag in the MSB above the message word.
    typedef struct packed {
        logic                 enc;
        logic [RSA_WIDTH-1:0] msg;
    } rsa_entry_t;

endpackage

// File: rtl/rsa_msg_fifo.sv
// rtl/rsa_msg_fifo.sv - DW x DEPTH synchronous message FIFO with full/empty flags
// clk, reset (async, active-low): clock and flush
// wr_en/wr_data: push; rd_en/rd_data: pop, rd_data shows the head combinationally
// full/empty: occupancy flags
module rsa_msg_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_wr, do_rd;

    // A write on a full FIFO is legal when the head leaves in the same cycle.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (do_rd) rptr <= rptr + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rsa_seq_ctrl.sv
// rtl/rsa_seq_ctrl.sv - RSA sequencing controller: key generation, message queue, mod_exp control
// Optional macro RSA_SEQ_TIMEOUT_EN: abort inverter/mod_exp operations after TIMEOUT cycles.
// clk, reset (async, active-low)
// p, q, key_load: primes and key generation request
// inv_start/inv_done/inv_e/inv_d: inverter handshake and exponents
// in_valid/in_ready/in_msg/in_enc: message input stream
// exp_start/exp_base/exp_mod/exp_exp/exp_done/exp_result: mod_exp handshake
// out_valid/out_ready/out_data/out_err: result stream
// keys_valid, busy: status
module rsa_seq_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH   = RSA_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic               key_load,
    output logic               inv_start,
    input  logic               inv_done,
    input  logic [2*WIDTH-1:0] inv_e,
    input  logic [2*WIDTH-1:0] inv_d,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_msg,
    input  logic               in_enc,
    output logic               exp_start,
    output logic [2*WIDTH-1:0] exp_base,
    output logic [2*WIDTH-1:0] exp_mod,
    output logic [2*WIDTH-1:0] exp_exp,
    input  logic               exp_done,
    input  logic [2*WIDTH-1:0] exp_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               out_err,
    output logic               keys_valid,
    output logic               busy
);
    localparam int W2 = 2 * WIDTH;

    rsa_state_e     state, state_nxt;
    logic [W2-1:0]  n_reg, e_reg, d_reg;
    logic [WIDTH-1:0] cur_msg;
    logic           cur_enc;
    logic           ready_en;
    logic           out_to_idle;
    logic           key_accept, fifo_pop, fifo_push;
    logic           fifo_full, fifo_empty;
    logic [WIDTH:0] fifo_rdata;
    logic           msg_oor;
    logic           tmo_hit;

    // ready_en holds in_ready low throughout reset and for the release edge.
    assign in_ready  = ready_en && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign busy      = !(state == ST_IDLE || state == ST_READY) || !fifo_empty;
    assign msg_oor   = ({{WIDTH{1'b0}}, cur_msg} >= n_reg);

    rsa_msg_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_push),
        .wr_data ({in_enc, in_msg}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef RSA_SEQ_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Counts cycles spent waiting on the inverter or mod_exp; cleared elsewhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if ((state == ST_KEYGEN || state == ST_EXP) && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == ST_KEYGEN || state == ST_EXP) && (tmo_cnt == 32'(TIMEOUT - 1));
`else
    // Without the timeout feature the controller waits forever for done.
    assign tmo_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        key_accept = 1'b0;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_load) begin
                    key_accept = 1'b1;
                    state_nxt  = ST_KEYGEN;
                end
            end
            ST_KEYGEN: begin
                if (inv_done)     state_nxt = ST_READY;
                else if (tmo_hit) state_nxt = ST_OUT;
            end
            ST_READY: begin
                // A new key request takes priority over queued messages.
                if (key_load) begin
                    key_accept = 1'b1;
                    state_nxt  = ST_KEYGEN;
                end else if (!fifo_empty && keys_valid) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:   state_nxt = msg_oor ? ST_OUT : ST_EXP;
            ST_EXP:    if (exp_done || tmo_hit) state_nxt = ST_OUT;
            ST_OUT:    if (out_ready) state_nxt = out_to_idle ? ST_IDLE : ST_READY;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en    <= 1'b0;
            n_reg       <= '0;
            e_reg       <= '0;
            d_reg       <= '0;
            keys_valid  <= 1'b0;
            cur_msg     <= '0;
            cur_enc     <= 1'b0;
            inv_start   <= 1'b0;
            exp_start   <= 1'b0;
            exp_base    <= '0;
            exp_mod     <= '0;
            exp_exp     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
            out_to_idle <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            inv_start <= key_accept;
            exp_start <= (state == ST_LOAD) && !msg_oor;

            if (key_accept) begin
                n_reg      <= W2'(p) * W2'(q);
                keys_valid <= 1'b0;
            end

            if (state == ST_KEYGEN) begin
                if (inv_done) begin
                    e_reg      <= inv_e;
                    d_reg      <= inv_d;
                    keys_valid <= 1'b1;
                end else if (tmo_hit) begin
                    // Failed key generation reports one error, then falls back to IDLE.
                    out_valid   <= 1'b1;
                    out_err     <= 1'b1;
                    out_data    <= '0;
                    out_to_idle <= 1'b1;
                end
            end

            if (fifo_pop) begin
                cur_msg <= fifo_rdata[WIDTH-1:0];
                cur_enc <= fifo_rdata[WIDTH];
            end

            if (state == ST_LOAD) begin
                if (msg_oor) begin
                    out_valid   <= 1'b1;
                    out_err     <= 1'b1;
                    out_data    <= '0;
                    out_to_idle <= 1'b0;
                end else begin
                    exp_base <= W2'(cur_msg);
                    exp_mod  <= n_reg;
                    exp_exp  <= cur_enc ? e_reg : d_reg;
                end
            end

            if (state == ST_EXP) begin
                if (exp_done) begin
                    out_valid   <= 1'b1;
                    out_err     <= 1'b0;
                    out_data    <= exp_result;
                    out_to_idle <= 1'b0;
                end else if (tmo_hit) begin
                    out_valid   <= 1'b1;
                    out_err     <= 1'b1;
                    out_data    <= '0;
                    out_to_idle <= 1'b0;
                end
            end

            if (state == ST_OUT && out_ready) begin
                out_valid   <= 1'b0;
                out_err     <= 1'b0;
                out_to_idle <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rsa_seq_ctrl.md
Name: rsa_seq_ctrl

Overview:
- Parametrised sequencing controller for the RSA datapath; supersedes the fixed single-message control top.
- Drives one inverter (key generation) and one mod_exp (modular exponentiation) through start/done handshakes.
- Buffers a stream of messages, each tagged encrypt or decrypt, in an internal FIFO, and returns results over a valid/ready output.
- Sits between the UART/host front end and the text_gen/VGA display path.

Parameters:
- WIDTH, 32, bit width of p, q and message words; modulus, exponents and results are 2*WIDTH.
- DEPTH, 4, input FIFO entries; power of two, minimum 2.
- TIMEOUT, 65535, cycle limit per inverter or mod_exp operation (used only with RSA_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- p, q  in  WIDTH  primes, sampled on key_load.
- key_load  in  1  single-cycle pulse that requests key generation.
- inv_start  out  1  single-cycle start pulse to the inverter.
- inv_done  in  1  inverter finish.
- inv_e, inv_d  in  2*WIDTH  generated exponents, valid while inv_done=1.
- in_valid / in_ready  in / out  1  message input handshake.
- in_msg  in  WIDTH  message or cipher word.
- in_enc  in  1  1 = encrypt (uses e), 0 = decrypt (uses d).
- exp_start  out  1  single-cycle start pulse to mod_exp.
- exp_base, exp_mod, exp_exp  out  2*WIDTH  mod_exp operands, registered and stable from exp_start until exp_done.
- exp_done  in  1  mod_exp finish.
- exp_result  in  2*WIDTH  mod_exp result.
- out_valid / out_ready  out / in  1  result handshake.
- out_data  out  2*WIDTH  result word.
- out_err  out  1  result is an error marker (out_data=0).
- keys_valid  out  1  e, d and n are held and valid.
- busy  out  1  state is not IDLE or READY, or the FIFO is non-empty.

Behaviour:
- Reset values: all outputs 0; FIFO empty; key registers cleared. in_ready stays 0 while reset is asserted and becomes 1 on the first cycle after release.
- States: IDLE, KEYGEN, READY, LOAD, EXP, OUT.
- IDLE:
  - key_load: latch p and q, register n = p*q (2*WIDTH), pulse inv_start the next cycle, go to KEYGEN.
- KEYGEN:
  - On inv_done: latch e and d, set keys_valid, go to READY.
- READY:
  - If the FIFO is non-empty, pop the head and go to LOAD.
  - key_load is accepted only in IDLE or READY. If it coincides with a non-empty FIFO in READY, key_load wins.
  - Accepting key_load clears keys_valid; entries already queued are processed with the new keys.
- LOAD (1 cycle):
  - If msg >= n: skip mod_exp, go to OUT with out_err=1 and out_data=0.
  - Otherwise drive exp_base = zero-extended msg, exp_mod = n, exp_exp = in_enc ? e : d; pulse exp_start; go to EXP.
- EXP:
  - On exp_done: register exp_result into out_data, go to OUT.
- OUT:
  - Hold out_valid=1 with data stable until out_ready=1.
  - When out_ready is seen, go to READY. Total latency from pop to out_valid is mod_exp time + 2 cycles.
- FIFO:
  - in_ready = !full; the FIFO is written on in_valid && in_ready in any state.
  - Entries may be accepted before keys exist; they are not popped until keys_valid=1.
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle on a full FIFO is allowed; the occupancy count is unchanged.
  - Push on a full FIFO is impossible, since in_ready=0.
- key_load pulses arriving in KEYGEN, LOAD, EXP or OUT are ignored, with no pending latch.
- A reset assertion in any state immediately returns the block to IDLE, flushes the FIFO and drops out_valid.

Optional Feature:
- Macro RSA_SEQ_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in KEYGEN and EXP. Reaching TIMEOUT without the matching done aborts the operation.
  - KEYGEN timeout: return to IDLE with keys_valid=0 and emit one out_err result (out_data=0).
  - EXP timeout: go to OUT with out_err=1 and out_data=0.
  - A done arriving later is ignored.
- When undefined: no counter; the block waits indefinitely for done.

Decomposition:
- Shared package rsa_pkg holds:
  - the state enum constants;
  - the WIDTH default;
  - FIFO entry layout, WIDTH+1 bits with in_enc in the MSB.
- One sub-module, rsa_msg_fifo (parametrised WIDTH+1 x DEPTH synchronous FIFO with full/empty flags), is natural.
- The FSM, key registers and operand registers stay in rsa_seq_ctrl.

Test Plan:
- Basic encrypt:
  - p=3, q=11, key_load; inverter model returns e=3, d=7.
  - keys_valid=1, n=33.
  - Push msg=2 with enc=1: exp_exp=3, exp_mod=33; out_data=8, out_err=0.
- Decrypt round trip: push msg=8 with enc=0 → exp_exp=7, out_data=2.
- Backpressure and FIFO fill:
  - With DEPTH=4, push 5 messages before keys exist: in_ready drops after the 4th.
  - After keygen, results for 2,4,5,7 arrive in order.
  - Holding out_ready=0 for 10 cycles keeps out_data stable.
- Out-of-range input: n=33, push msg=40 → out_err=1, out_data=0, and no exp_start pulse.
- Busy-state key_load: a key_load pulse during EXP is ignored; keys_valid stays 1 and e/d are unchanged.
- Reset and timeout:
  - Reset asserted during EXP: all outputs return to 0, in_ready=1 after release, and the FIFO is empty.
  - With RSA_SEQ_TIMEOUT_EN and TIMEOUT=16, a mod_exp model that never finishes gives out_err=1 after 16 cycles.
